// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : request FSM state (IDLE / WAIT / DROP)
//   fetch_entry_t : one fetch-buffer entry {pc, instr} at the default XLEN
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden by the top
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0060;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Circular fetch buffer with head/tail pointers and a separate occupancy
// count. A flush empties the buffer in one cycle and overrides enq/deq.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   flush        : drop all entries (wins over enq/deq)
//   enq/enq_data : push an entry (ignored when full)
//   deq          : pop the head (ignored when empty)
//   deq_valid    : head entry present
//   deq_data     : head entry, read straight from storage
//   count        : occupied entries
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq,
    input  entry_t                       enq_data,
    input  logic                         deq,
    output logic                         deq_valid,
    output entry_t                       deq_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               do_enq;
    logic               do_deq;

    assign do_enq    = enq && (count != FULL_CNT);
    assign do_deq    = deq && (count != '0);
    assign deq_valid = (count != '0);
    assign deq_data  = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) tail <= tail + 1'b1;
            if (do_deq) head <= head + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_enq && !flush) mem[tail] <= enq_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// RV32I instruction-fetch front end: PC register, single-outstanding imem
// request/response handshake, prioritised redirect mux and a DEPTH-entry
// fetch buffer feeding the IF/ID register.
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   imem_read, imem_address     : registered fetch request (held until resp)
//   imem_resp, imem_rdata       : response strobe and instruction word
//   redir_mem_valid/_pc         : MEM-stage correction (highest priority)
//   redir_id_valid/_pc          : ID-stage predicted-taken redirect
//   deq_ready                   : ID accepts the head instruction
//   deq_valid, deq_pc, deq_instr: buffer head, straight from storage
//   buf_count                   : occupied buffer entries
// ---------------------------------------------------------------------------
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_read,
    output logic [XLEN-1:0]            imem_address,
    input  logic                       imem_resp,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redir_mem_valid,
    input  logic [XLEN-1:0]            redir_mem_pc,
    input  logic                       redir_id_valid,
    input  logic [XLEN-1:0]            redir_id_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic            redir;
    logic [XLEN-1:0] redir_target;
    logic            issue;
    logic            accept;
    entry_t          enq_entry;
    entry_t          head_entry;

    // MEM correction outranks the ID prediction; targets are word aligned.
    always_comb begin
        redir        = redir_mem_valid || redir_id_valid;
        redir_target = redir_mem_valid ? redir_mem_pc : redir_id_pc;
        redir_target[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!redir && (buf_count != FULL_CNT)) state_next = WAIT;
            // A response in the redirect cycle is consumed and discarded,
            // so only an unanswered request needs the DROP state.
            WAIT: begin
                if (imem_resp)  state_next = IDLE;
                else if (redir) state_next = DROP;
            end
            DROP: if (imem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue  = (state == IDLE) && (state_next == WAIT);
        accept = (state == WAIT) && imem_resp && !redir;
    end

    // imem_read tracks the next state so it stays high for the whole
    // handshake and drops the cycle after the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_read <= 1'b0;
            fetch_pc  <= RESET_PC;
        end else begin
            imem_read <= (state_next != IDLE);
            if (redir)       fetch_pc <= redir_target;
            else if (accept) fetch_pc <= imem_address + XLEN'(4);
        end
    end

    // Address is captured only on issue, keeping it stable mid-handshake.
    always_ff @(posedge clk) begin
        if (issue) imem_address <= fetch_pc;
    end

    assign enq_entry = '{pc: imem_address, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir),
        .enq       (accept),
        .enq_data  (enq_entry),
        .deq       (deq_ready),
        .deq_valid (deq_valid),
        .deq_data  (head_entry),
        .count     (buf_count)
    );

    assign deq_pc    = head_entry.pc;
    assign deq_instr = head_entry.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] KEY = 32'h1357_9BDF;
    localparam logic [31:0] RST_PC = 32'h0000_0060;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redir_mem_valid;
    logic [31:0] redir_mem_pc;
    logic        redir_id_valid;
    logic [31:0] redir_id_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  buf_count;

    if_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_read       (imem_read),
        .imem_address    (imem_address),
        .imem_resp       (imem_resp),
        .imem_rdata      (imem_rdata),
        .redir_mem_valid (redir_mem_valid),
        .redir_mem_pc    (redir_mem_pc),
        .redir_id_valid  (redir_id_valid),
        .redir_id_pc     (redir_id_pc),
        .deq_ready       (deq_ready),
        .deq_valid       (deq_valid),
        .deq_pc          (deq_pc),
        .deq_instr       (deq_instr),
        .buf_count       (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a queue of fetched {pc, instr}, one
    // outstanding request that may be marked stale, and the next fetch PC.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    initial begin
        m_out = 0;
        m_stale = 0;
        m_pc = RST_PC;
        m_addr = 32'h0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_q.delete();
                m_out = 0;
                m_stale = 0;
                m_pc = RST_PC;
            end else begin
                bit          r;
                bit          was_out;
                bit          got;
                int          sz;
                logic [31:0] tgt;
                r       = redir_mem_valid || redir_id_valid;
                tgt     = redir_mem_valid ? redir_mem_pc : redir_id_pc;
                tgt     = tgt & 32'hFFFF_FFFC;
                was_out = m_out;
                got     = m_out && imem_resp;
                sz      = m_q.size();
                if (r) begin
                    m_q.delete();
                    m_pc = tgt;
                    if (m_out && !imem_resp) m_stale = 1;
                end else begin
                    if (deq_ready && sz > 0) void'(m_q.pop_front());
                    if (got && !m_stale) begin
                        m_q.push_back('{pc: m_addr, instr: imem_rdata});
                        m_pc = m_addr + 32'd4;
                    end
                end
                if (got) begin
                    m_out = 0;
                    m_stale = 0;
                end else if (!was_out && !r && sz < DEPTH) begin
                    m_out = 1;
                    m_addr = m_pc;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("imem_read", 32'(imem_read), 32'(m_out));
            if (m_out) chk("imem_address", imem_address, m_addr);
            chk("deq_valid", 32'(deq_valid), 32'(m_q.size() > 0));
            chk("buf_count", 32'(buf_count), 32'(m_q.size()));
            if (m_q.size() > 0) begin
                chk("deq_pc", deq_pc, m_q[0].pc);
                chk("deq_instr", deq_instr, m_q[0].instr);
            end
        end
    end

    // Record every request address as it first appears.
    logic [31:0] iss_q[$];
    bit          prev_read = 0;
    int          max_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (imem_read && !prev_read) iss_q.push_back(imem_address);
        prev_read = imem_read;
        if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
    end

    function automatic logic [31:0] iss_at(input int i);
        if (i < iss_q.size()) return iss_q[i];
        return 32'hBAD0_BAD1;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus: memory answers after lat cycles of imem_read being high.
    // ------------------------------------------------------------------
    int lat = 1;
    int age = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_read) age++;
        else age = 0;
        if (imem_read && age == lat + 1) begin
            imem_resp  = 1'b1;
            imem_rdata = imem_address ^ KEY;
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        redir_mem_valid = 1'b0;
        redir_id_valid  = 1'b0;
        deq_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        iss_q.delete();
        max_cnt = 0;
    endtask

    task automatic wait_iss(input int n, input string name);
        int k = 0;
        while (iss_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (iss_q.size() < n) fail_timeout(name);
    endtask

    task automatic wait_read(input string name);
        int k = 0;
        while (!imem_read && k < 200) begin
            tick();
            k++;
        end
        if (!imem_read) fail_timeout(name);
    endtask

    task automatic wait_dv(input string name);
        int k = 0;
        while (!deq_valid && k < 200) begin
            tick();
            k++;
        end
        if (!deq_valid) fail_timeout(name);
    endtask

    task automatic wait_cnt(input int c, input string name);
        int k = 0;
        while (int'(buf_count) != c && k < 200) begin
            tick();
            k++;
        end
        if (int'(buf_count) != c) fail_timeout(name);
    endtask

    initial begin
        rst = 1'b0;
        imem_resp = 1'b0;
        imem_rdata = 32'h0;
        redir_mem_valid = 1'b0;
        redir_mem_pc = 32'h0;
        redir_id_valid = 1'b0;
        redir_id_pc = 32'h0;
        deq_ready = 1'b0;

        // Reset state
        reset_dut();
        cmp_en = 1;
        chk("rst_imem_read", 32'(imem_read), 32'h0);
        chk("rst_deq_valid", 32'(deq_valid), 32'h0);
        chk("rst_buf_count", 32'(buf_count), 32'h0);

        // Streaming fetch with ID always ready
        lat = 1;
        deq_ready = 1'b1;
        wait_dv("t1_first");
        chk("t1_head_pc", deq_pc, 32'h0000_0060);
        chk("t1_head_instr", deq_instr, 32'h1357_9BBF);
        wait_iss(3, "t1_iss");
        chk("t1_addr0", iss_at(0), 32'h0000_0060);
        chk("t1_addr1", iss_at(1), 32'h0000_0064);
        chk("t1_addr2", iss_at(2), 32'h0000_0068);
        repeat (4) tick();
        chk("t1_max_count", 32'(max_cnt), 32'd1);

        // Fill with ID stalled, then a single pop
        reset_dut();
        lat = 1;
        wait_cnt(4, "t2_fill");
        repeat (3) tick();
        chk("t2_full_count", 32'(buf_count), 32'd4);
        chk("t2_full_noread", 32'(imem_read), 32'h0);
        chk("t2_nreq", 32'(iss_q.size()), 32'd4);
        chk("t2_head", deq_pc, 32'h0000_0060);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk("t2_pop_count", 32'(buf_count), 32'd3);
        chk("t2_pop_head", deq_pc, 32'h0000_0064);
        wait_iss(5, "t2_next");
        chk("t2_next_addr", iss_at(4), 32'h0000_0070);

        // MEM redirect while waiting; stale response dropped
        reset_dut();
        lat = 3;
        deq_ready = 1'b1;
        wait_read("t3_req");
        redir_mem_valid = 1'b1;
        redir_mem_pc = 32'h0000_0200;
        tick();
        redir_mem_valid = 1'b0;
        chk("t3_drop_count", 32'(buf_count), 32'h0);
        chk("t3_drop_hold", imem_address, 32'h0000_0060);
        wait_iss(2, "t3_next");
        chk("t3_next_addr", iss_at(1), 32'h0000_0200);
        chk("t3_no_stale", 32'(deq_valid), 32'h0);
        wait_dv("t3_dv");
        chk("t3_head", deq_pc, 32'h0000_0200);

        // Both redirects with a response in the same cycle
        reset_dut();
        lat = 1;
        deq_ready = 1'b1;
        wait_read("t4_req");
        tick();
        redir_mem_valid = 1'b1;
        redir_mem_pc = 32'h0000_0300;
        redir_id_valid = 1'b1;
        redir_id_pc = 32'h0000_0400;
        tick();
        redir_mem_valid = 1'b0;
        redir_id_valid = 1'b0;
        chk("t4_count", 32'(buf_count), 32'h0);
        chk("t4_dv", 32'(deq_valid), 32'h0);
        wait_iss(2, "t4_next");
        chk("t4_next_addr", iss_at(1), 32'h0000_0300);

        // ID redirect on a full buffer with a pop attempt
        reset_dut();
        lat = 1;
        wait_cnt(4, "t5_fill");
        redir_id_valid = 1'b1;
        redir_id_pc = 32'h0000_1002;
        deq_ready = 1'b1;
        tick();
        redir_id_valid = 1'b0;
        deq_ready = 1'b0;
        chk("t5_flush_count", 32'(buf_count), 32'h0);
        chk("t5_flush_dv", 32'(deq_valid), 32'h0);
        wait_iss(5, "t5_next");
        chk("t5_next_addr", iss_at(4), 32'h0000_1000);
        wait_dv("t5_dv");
        chk("t5_head_pc", deq_pc, 32'h0000_1000);
        chk("t5_head_instr", deq_instr, 32'h1357_8BDF);

        // Reset during WAIT, late response after release
        reset_dut();
        lat = 5;
        wait_read("t6_req");
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        imem_resp = 1'b1;
        imem_rdata = 32'hDEAD_0001;
        wait_iss(2, "t6_next");
        chk("t6_addr", iss_at(1), 32'h0000_0060);
        chk("t6_count", 32'(buf_count), 32'h0);
        wait_dv("t6_dv");
        chk("t6_head", deq_pc, 32'h0000_0060);

        // PC wrap past the top of the address space
        rst = 1'b0;
        repeat (3) tick();
        iss_q.delete();
        lat = 1;
        deq_ready = 1'b1;
        rst = 1'b1;
        redir_mem_valid = 1'b1;
        redir_mem_pc = 32'hFFFF_FFFE;
        tick();
        redir_mem_valid = 1'b0;
        wait_iss(2, "t7_wrap");
        chk("t7_addr_top", iss_at(0), 32'hFFFF_FFFC);
        chk("t7_addr_wrap", iss_at(1), 32'h0000_0000);
        repeat (3) tick();

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the fixed magic-memory IF control with a PC register, a real imem request/response handshake, and a DEPTH-entry fetch buffer that decouples fetch from ID stalls. Redirects are prioritised: MEM-stage branch/jalr correction first, then ID-stage predicted-taken. An epoch/drop state discards stale responses after a redirect. The block sits between the I-cache port and the IF/ID pipeline register.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, fetch buffer entries (power of 2, >= 2)
RESET_PC, 32'h0000_0060, PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
imem_read  out  1  fetch request valid
imem_address  out  XLEN  fetch address, word aligned
imem_resp  in  1  response strobe, one cycle per request
imem_rdata  in  XLEN  instruction word, valid with imem_resp
redir_mem_valid  in  1  MEM-stage mispredict correction
redir_mem_pc  in  XLEN  corrected target
redir_id_valid  in  1  ID-stage predicted-taken redirect
redir_id_pc  in  XLEN  predicted target
deq_ready  in  1  ID accepts an instruction (deasserted while the pipe is bubbling)
deq_valid  out  1  buffer head valid
deq_pc  out  XLEN  PC of head instruction
deq_instr  out  XLEN  head instruction
buf_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst==0 at a clk edge): fetch_pc<=RESET_PC, state IDLE, buffer empty, imem_read=0, deq_valid=0, buf_count=0. Any outstanding request is abandoned; an imem_resp arriving in IDLE is ignored.
- States:
  - IDLE: issue if buf_count<DEPTH and no redirect this cycle. Assert imem_read with imem_address=fetch_pc, then go to WAIT.
  - WAIT: hold imem_read=1 with a stable address until imem_resp. The address must never change mid-handshake.
  - DROP: request outstanding but stale. Hold imem_read/address; on imem_resp discard the data and go to IDLE.
- Only one request is outstanding at a time. Because issue requires buf_count<DEPTH, a response always has a free slot.
- Accepted response (WAIT, imem_resp, no redirect): enqueue {pc=request address, instr=imem_rdata}. fetch_pc<=request address+4, wrapping mod 2^XLEN. Go to IDLE; the next issue can occur in the following cycle.
- Latency: imem_resp at cycle N -> deq_valid at N+1 (no empty bypass).
- Dequeue: deq_valid = buf_count>0. The handshake is deq_valid&deq_ready, which pops the head. Simultaneous enqueue and dequeue keep buf_count unchanged.
- Redirect priority: mem > id. Target = selected pc with bits [1:0] forced to 0. On any redirect:
  - flush the buffer (buf_count<=0);
  - fetch_pc<=target;
  - any dequeue handshake in the same cycle is void;
  - IDLE -> IDLE, with no issue that cycle.
  - WAIT with no imem_resp -> DROP. WAIT with imem_resp in the same cycle -> discard the data, go to IDLE.
  - DROP -> stays DROP; a later redirect just overwrites fetch_pc.
- Both redirects in one cycle: mem target wins; id is ignored.
- Full buffer: no issue. A full buffer with deq_ready=1 pops, and the issue follows on the next cycle.
- All outputs are registered except deq_valid/deq_pc/deq_instr, which are driven directly from buffer storage.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DROP};
  - fetch_entry_t struct {pc, instr};
  - RESET_PC default constant.
- Sub-module fetch_fifo (DEPTH, entry type):
  - circular buffer with head/tail pointers of log2(DEPTH) bits;
  - separate count;
  - single-cycle flush input that overrides enq/deq.
- if_fetch_unit holds the FSM, fetch_pc and redirect mux, and instantiates fetch_fifo.

Test Plan:
- Reset release, imem_resp one cycle after each request, deq_ready=1 -> addresses 0x60, 0x64, 0x68 issued. deq_pc follows one cycle after each resp; buf_count stays <=1.
- deq_ready=0, DEPTH=4 -> exactly 4 responses enqueued. imem_read stays 0 with buf_count=4. Raising deq_ready for one cycle -> pop of 0x60, then the next request to 0x70.
- redir_mem_valid with pc 0x200 while in WAIT, resp 3 cycles later -> state DROP, stale data not enqueued, buf_count=0, next request address 0x200.
- Same-cycle redir_mem (0x300) and redir_id (0x400), with imem_resp also in that cycle -> data discarded, next request 0x300.
- redir_id_pc=0x1002 with a full buffer and deq_ready=1 -> buffer flushed, no pop counted, next address 0x1000.
- rst=0 asserted in WAIT, imem_resp arriving after reset release -> response ignored, first request 0x60, buf_count=0; fetch_pc 0xFFFF_FFFC wraps to 0x0.
